ioctl_rom_loader: RTL

Sequences HPS/host ioctl ROM downloads into the Centipede core's program and graphics ROM write ports. The block buffers incoming bytes in a 4-entry FIFO and throttles the host with ioctl_wait. It decodes each byte's address to a ROM region and drives a req/ack memory write port. The centipede core is held in reset until the image is fully written and a settle interval has elapsed. It sits in the top-level wrapper, between the ioctl bus and the ROM/RAM resources feeding the centipede core.

---
 rtl/ioctl_rom_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ioctl_rom_loader.sv
// rtl/ioctl_rom_loader.sv - ioctl ROM download sequencer for the centipede core ROM write ports
module ioctl_rom_loader #(
  parameter logic [7:0] ROM_INDEX   = 8'd0,
  parameter int         HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [1:0]  mem_sel,
  output logic [12:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        core_reset,
  output logic        load_done,
  output logic [15:0] byte_count,
  output logic [7:0]  drop_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_HOLD, S_RUN} state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  hold_cnt, hold_next;
  logic        clear_counts;

  logic [22:0] fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  fifo_cnt, fifo_cnt_next;

  logic        match, accept, in_range, fifo_empty, fifo_full;
  logic        push, pop, drop, ack_seen;
  logic [1:0]  push_sel;
  logic [12:0] push_addr;

  assign match      = ioctl_download && (ioctl_index == ROM_INDEX);
  assign accept     = ioctl_wr && match && (state == S_LOAD);
  assign in_range   = (ioctl_addr < 25'h3000);
  assign fifo_empty = (fifo_cnt == 3'd0);
  assign fifo_full  = (fifo_cnt == 3'd4);
  // The output register takes the head whenever it is free or being freed this edge
  assign pop        = !fifo_empty && (!mem_req || mem_ack);
  // A full FIFO still accepts when a pop makes room on the same edge
  assign push       = accept && in_range && (!fifo_full || pop);
  assign drop       = accept && !push;
  assign ack_seen   = mem_req && mem_ack;

  // Region decode: bit 13 separates program (0x0000-0x1FFF) from graphics (0x2000-0x2FFF)
  assign push_sel   = ioctl_addr[13] ? 2'b10 : 2'b01;
  assign push_addr  = ioctl_addr[13] ? {1'b0, ioctl_addr[11:0]} : ioctl_addr[12:0];

  assign core_reset = (state != S_RUN);
  assign load_done  = (state == S_RUN);

  // FIFO occupancy after this edge
  always_comb begin
    fifo_cnt_next = fifo_cnt;
    if (push && !pop)
      fifo_cnt_next = fifo_cnt + 3'd1;
    else if (pop && !push)
      fifo_cnt_next = fifo_cnt - 3'd1;
  end

  // Next-state logic; a matching download always wins over drain/hold progress
  always_comb begin
    state_next   = state;
    hold_next    = hold_cnt;
    clear_counts = 1'b0;
    case (state)
      S_IDLE: begin
        if (match) begin
          state_next   = S_LOAD;
          clear_counts = 1'b1;
        end
      end
      S_LOAD: begin
        if (!ioctl_download)
          state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (match)
          state_next = S_LOAD;
        else if (fifo_empty && !mem_req) begin
          state_next = S_HOLD;
          hold_next  = HOLD_M1;
        end
      end
      S_HOLD: begin
        if (match)
          state_next = S_LOAD;
        else if (hold_cnt == 8'd0)
          state_next = S_RUN;
        else
          hold_next = hold_cnt - 8'd1;
      end
      S_RUN: begin
        if (match) begin
          state_next   = S_LOAD;
          clear_counts = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, hold counter and host throttle registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      hold_cnt   <= 8'd0;
      ioctl_wait <= 1'b0;
    end else begin
      state      <= state_next;
      hold_cnt   <= hold_next;
      ioctl_wait <= (state_next == S_LOAD) && (fifo_cnt_next >= 3'd3);
    end
  end

  // FIFO storage; the pointers alone define which entries are valid
  always_ff @(posedge clk_sys) begin
    if (push)
      fifo_mem[wr_ptr] <= {push_sel, push_addr, ioctl_dout};
  end

  // FIFO pointers and occupancy; reset flushes the queue
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt_next;
    end
  end

  // Memory write port; fields only change when a new entry is loaded
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_req  <= 1'b0;
      mem_sel  <= 2'b00;
      mem_addr <= 13'd0;
      mem_data <= 8'd0;
    end else if (pop) begin
      mem_req                       <= 1'b1;
      {mem_sel, mem_addr, mem_data} <= fifo_mem[rd_ptr];
    end else if (ack_seen) begin
      mem_req <= 1'b0;
    end
  end

  // Acknowledged and dropped byte counters, cleared on entry to a fresh load
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      byte_count <= 16'd0;
      drop_count <= 8'd0;
    end else if (clear_counts) begin
      byte_count <= 16'd0;
      drop_count <= 8'd0;
    end else begin
      if (ack_seen)
        byte_count <= byte_count + 16'd1;
      if (drop && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule
